// File: rtl/tone_sequencer_pkg.sv
// Shared definitions for the tone sequencer: state encoding, queue-entry field layout
// and the range of note codes that map to audible semitones.
package tone_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        GAP  = 2'd2
    } seq_state_e;

    localparam int ENTRY_W  = 16;
    localparam int NOTE_MSB = 15;
    localparam int NOTE_LSB = 12;
    localparam int DUR_MSB  = 11;
    localparam int DUR_LSB  = 0;
    localparam int DUR_W    = DUR_MSB - DUR_LSB + 1;
    localparam int NOTE_MIN = 1;
    localparam int NOTE_MAX = 13;

    // Codes outside NOTE_MIN..NOTE_MAX are rests and drive the beeper silent.
    function automatic logic [7:0] note_to_mode(input logic [3:0] note);
        if (int'(note) >= NOTE_MIN && int'(note) <= NOTE_MAX) begin
            return {4'h0, note};
        end
        return 8'h00;
    endfunction

endpackage

// File: rtl/tone_fifo.sv
// Parametric synchronous FIFO for queued note entries. A push into a full queue is
// dropped even if a pop happens on the same edge; clr empties the queue.
module tone_fifo
    import tone_sequencer_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = ENTRY_W,
    localparam int AW = $clog2(DEPTH),
    localparam int LW = AW + 1
) (
    input  logic             clk,
    input  logic             reset_,
    input  logic             clr_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic [LW-1:0]    level_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full_o  = (count_q == LW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign level_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign push_ok = push_i && !full_o && !clr_i;
    assign pop_ok  = pop_i && !empty_o && !clr_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clr_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + LW'(1);
                2'b01:   count_d = count_q - LW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Storage carries no reset: stale contents are unreachable once the pointers clear.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/tone_sequencer.sv
// Plays queued {note, duration_ms} entries to a beep generator, one note at a time.
// Define TONESEQ_GAP_EN to insert a 1 ms silent articulation gap after every note.
module tone_sequencer
    import tone_sequencer_pkg::*;
#(
    parameter int DEPTH    = 8,
    parameter int TICK_DIV = 62500
) (
    input  logic        clk,
    input  logic        reset_,
    input  logic        wr,
    input  logic [15:0] wdata,
    input  logic        clr,
    output logic [7:0]  mode,
    output logic [31:0] status,
    output logic        busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    logic [ENTRY_W-1:0] head;
    logic [LW-1:0]      level;
    logic               full;
    logic               empty;
    logic               pop;
    logic [3:0]         level_sat;
    logic [3:0]         head_note;
    logic [DUR_W-1:0]   head_dur;
    logic               tick_wrap;
    logic               start_next;

    seq_state_e       state_q, state_d;
    logic [7:0]       mode_q, mode_d;
    logic [DUR_W-1:0] dur_q, dur_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic             ovf_q, ovf_d;

    tone_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .reset_  (reset_),
        .clr_i   (clr),
        .push_i  (wr),
        .pop_i   (pop),
        .wdata_i (wdata),
        .rdata_o (head),
        .level_o (level),
        .full_o  (full),
        .empty_o (empty)
    );

    assign head_note = head[NOTE_MSB:NOTE_LSB];
    assign head_dur  = head[DUR_MSB:DUR_LSB];
    assign tick_wrap = (presc_q == PRESC_LAST);

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        dur_d      = dur_q;
        presc_d    = presc_q;
        ovf_d      = ovf_q;
        pop        = 1'b0;
        start_next = 1'b0;
        if (clr) begin
            state_d = IDLE;
            mode_d  = 8'h00;
            dur_d   = '0;
            presc_d = '0;
            ovf_d   = 1'b0;
        end else begin
            ovf_d = ovf_q | (wr & full);
            case (state_q)
                IDLE: begin
                    start_next = !empty;
                end
                PLAY: begin
                    if (tick_wrap) begin
                        presc_d = '0;
                        dur_d   = dur_q - DUR_W'(1);
                        if (dur_q <= DUR_W'(1)) begin
                            mode_d  = 8'h00;
`ifdef TONESEQ_GAP_EN
                            state_d = GAP;
`else
                            state_d    = IDLE;
                            start_next = !empty;
`endif
                        end
                    end else begin
                        presc_d = presc_q + PW'(1);
                    end
                end
`ifdef TONESEQ_GAP_EN
                GAP: begin
                    if (tick_wrap) begin
                        presc_d    = '0;
                        state_d    = IDLE;
                        start_next = !empty;
                    end else begin
                        presc_d = presc_q + PW'(1);
                    end
                end
`endif
                default: begin
                    state_d = IDLE;
                    mode_d  = 8'h00;
                end
            endcase

            // Zero-duration entries are consumed here without touching mode.
            if (start_next) begin
                pop = 1'b1;
                if (head_dur != '0) begin
                    state_d = PLAY;
                    mode_d  = note_to_mode(head_note);
                    dur_d   = head_dur;
                    presc_d = '0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state_q <= IDLE;
            mode_q  <= 8'h00;
            dur_q   <= '0;
            presc_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            dur_q   <= dur_d;
            presc_q <= presc_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        if (32'(level) > 32'd15) level_sat = 4'hF;
        else                     level_sat = 4'(level);
    end

    assign mode   = mode_q;
    assign busy   = (state_q != IDLE);
    assign status = {24'h0, ovf_q, busy, full, empty, level_sat};

endmodule

// File: tb/tb_tone_sequencer.sv
// Scoreboard bench for tone_sequencer (DEPTH=4, TICK_DIV=10): stimulus pushes expected
// busy segments {mode, length, start cycle}; a monitor pops them as segments end.
module tb_tone_sequencer;

    typedef struct {
        int m;
        int len;
        int start;
    } seg_t;

    logic        clk = 1'b0;
    logic        reset_ = 1'b1;
    logic        wr = 1'b0;
    logic [15:0] wdata = 16'h0;
    logic        clr = 1'b0;
    logic [7:0]  mode;
    logic [31:0] status;
    logic        busy;

    int   cyc = 0;
    int   passed = 0;
    int   total = 0;
    seg_t exp_q[$];
    logic [8:0] mon_prev = 9'h0;
    logic [8:0] mon_cur;
    int   seg_start = 0;

    tone_sequencer #(.DEPTH(4), .TICK_DIV(10)) dut (
        .clk    (clk),
        .reset_ (reset_),
        .wr     (wr),
        .wdata  (wdata),
        .clr    (clr),
        .mode   (mode),
        .status (status),
        .busy   (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) begin
            passed++;
            $display("check %s: got %h", name, act);
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic seg_check(input int m, input int len, input int start);
        seg_t e;
        total++;
        if (exp_q.size() == 0) begin
            $display("FAIL segment: unexpected mode=%0d len=%0d start=%0d", m, len, start);
        end else begin
            e = exp_q.pop_front();
            if (m == e.m && len == e.len && start == e.start) begin
                passed++;
                $display("segment mode=%0d len=%0d start=%0d ok", m, len, start);
            end else begin
                $display("FAIL segment: got mode=%0d len=%0d start=%0d expected mode=%0d len=%0d start=%0d",
                         m, len, start, e.m, e.len, e.start);
            end
        end
    endtask

    task automatic push_exp(input int m, input int len, input int start);
        seg_t e;
        e.m = m;
        e.len = len;
        e.start = start;
        exp_q.push_back(e);
    endtask

    // Monitor: a transaction is a maximal run of constant {busy, mode} with busy high.
    always @(negedge clk) begin
        mon_cur = {busy, mode};
        if (mon_cur !== mon_prev) begin
            if (mon_prev[8]) seg_check(int'(mon_prev[7:0]), cyc - seg_start, seg_start);
            seg_start = cyc;
            mon_prev  = mon_cur;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_write(input logic [15:0] w, output int t);
        wr = 1'b1;
        wdata = w;
        t = cyc;
        @(negedge clk);
        wr = 1'b0;
    endtask

    initial begin
        int t, t2, c;
        #1 reset_ = 1'b0;
        #1;
        chk("reset_mode", 32'(mode), 32'h0);
        chk("reset_status", status, 32'h10);
        chk("reset_busy", 32'(busy), 32'h0);
        tick(2);
        reset_ = 1'b1;
        tick(2);

        // Single note: mode 5 one edge after the write lands, held 30 cycles.
        do_write(16'h5003, t);
        push_exp(5, 30, t + 2);
        tick(1);
        chk("t1_mode_start", 32'(mode), 32'h5);
        tick(34);
        chk("t1_idle_mode", 32'(mode), 32'h0);
        chk("t1_idle_busy", 32'(busy), 32'h0);

        // Back-to-back notes.
        do_write(16'h1002, t);
        do_write(16'h8001, t2);
        push_exp(1, 20, t + 2);
`ifdef TONESEQ_GAP_EN
        push_exp(0, 10, t + 22);
        push_exp(8, 10, t + 32);
`else
        push_exp(8, 10, t + 22);
`endif
        tick(50);
        chk("t2_idle_status", status, 32'h10);

        // Overflow: fill the queue while a long note plays, then flush with a concurrent write.
        do_write(16'h2005, t);
        tick(3);
        do_write(16'h3001, t2);
        do_write(16'h4001, t2);
        do_write(16'h6001, t2);
        do_write(16'h7001, t2);
        do_write(16'h9001, t2);
        chk("t3_status_ovf", status, 32'hE4);
        chk("t3_mode_playing", 32'(mode), 32'h2);
        c = cyc;
        clr = 1'b1;
        wr = 1'b1;
        wdata = 16'h3005;
        push_exp(2, c + 1 - (t + 2), t + 2);
        @(negedge clk);
        clr = 1'b0;
        wr = 1'b0;
        chk("t3_clr_status", status, 32'h10);
        chk("t3_clr_mode", 32'(mode), 32'h0);
        tick(5);
        chk("t3_clr_wr_dropped", status, 32'h10);

        // Zero-duration entry discarded, then a rest code plays silent but busy.
        do_write(16'h7000, t);
        do_write(16'hF002, t2);
        push_exp(0, 20, t + 3);
        chk("t4_discard_mode", 32'(mode), 32'h0);
        chk("t4_discard_busy", 32'(busy), 32'h0);
        tick(1);
        chk("t4_rest_busy", 32'(busy), 32'h1);
        tick(30);

        // Asynchronous reset mid-note with two entries queued.
        do_write(16'h4003, t);
        do_write(16'h6002, t2);
        do_write(16'h9002, t2);
        tick(7);
        c = cyc;
        #2 reset_ = 1'b0;
        push_exp(4, c + 1 - (t + 2), t + 2);
        #1;
        chk("t5_async_mode", 32'(mode), 32'h0);
        chk("t5_async_status", status, 32'h10);
        tick(2);
        reset_ = 1'b1;
        tick(40);
        chk("t5_after_status", status, 32'h10);
        chk("t5_after_mode", 32'(mode), 32'h0);
        do_write(16'h3001, t);
        push_exp(3, 10, t + 2);

        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
        while (exp_q.size() != 0) begin
            seg_t e;
            e = exp_q.pop_front();
            total++;
            $display("FAIL segment_missing: got none expected mode=%0d len=%0d start=%0d", e.m, e.len, e.start);
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
